// File: rtl/sag_ctrl_seq_if.sv
// rtl/sag_ctrl_seq_if.sv - request/result handshake bundle for the SAG control sequencer
interface sag_ctrl_seq_if #(parameter int LOG2N = 3);
   localparam int N = 1 << LOG2N;

   logic               in_valid;
   logic               in_ready;
   logic [N-1:0]       in_ci;
   logic [N-1:0]       in_di;
   logic               in_nr;
   logic               in_inv;
   logic               out_valid;
   logic               out_ready;
   logic [LOG2N*N-1:0] out_b;
   logic [N-1:0]       out_di;

   modport slave (
      input  in_valid, in_ci, in_di, in_nr, in_inv, out_ready,
      output in_ready, out_valid, out_b, out_di
   );

   modport master (
      output in_valid, in_ci, in_di, in_nr, in_inv, out_ready,
      input  in_ready, out_valid, out_b, out_di
   );
endinterface

// File: rtl/sag_ctrl_seq.sv
// rtl/sag_ctrl_seq.sv - sequential generator of SAG/NR-SAG butterfly control words
// One forward stage per cycle, then one backward stage per cycle, then a load of the packed result.
module sag_ctrl_seq #(
   parameter int LOG2N = 3
) (
   input  logic          clk,
   input  logic          rst,
   sag_ctrl_seq_if.slave bus
);
   localparam int N  = 1 << LOG2N;
   localparam int H  = N / 2;
   localparam int NS = 2 * LOG2N;
   localparam int KW = $clog2(LOG2N + 1);
   localparam logic [KW-1:0] K_LAST = KW'(LOG2N - 1);
   localparam logic [KW-1:0] K_FIN  = KW'(LOG2N);

   typedef enum logic [1:0] {IDLE, FWD, BWD, DONE} state_t;

   state_t             r_state;
   logic [KW-1:0]      r_k;
   logic [N-1:0]       r_c;
   logic [N-1:0]       r_di;
   logic               r_nr;
   logic               r_inv;
   logic [H-1:0]       r_lifo [LOG2N];
   logic [H-1:0]       r_slot [NS];
   logic               r_in_ready;
   logic               r_out_valid;
   logic [LOG2N*N-1:0] r_out_b;
   logic [N-1:0]       r_out_di;

   logic [N-1:0]       w_x;
   logic [N-1:0]       w_y;
   logic [N-1:0]       w_c_fwd;
   logic [N-1:0]       w_c_bwd;
   logic [H-1:0]       w_t_fwd;
   logic [H-1:0]       w_l_fwd;
   logic [H-1:0]       w_t_bwd;
   logic [LOG2N*N-1:0] w_b_pack;

   always_comb begin
      int          s;
      int          h;
      logic        acc;
      logic [H-1:0] l;
      s   = N >> r_k;
      h   = 0;
      acc = 1'b0;
      w_x = '0;
      // Running XOR restarts at every block boundary of size S.
      for (int i = 0; i < N; i++) begin
         acc    = ((i & (s - 1)) == 0) ? r_c[i] : (acc ^ r_c[i]);
         w_x[i] = acc;
      end
      l = '0;
      for (int j = 0; j < H; j++) begin
         w_t_fwd[j] = ~w_x[2*j];
         l[j]       = w_x[2*j+1];
      end
      for (int i = 1; i < LOG2N; i++) begin
         if (i > int'(r_k)) begin
            h = N >> (i + 1);
            for (int j = 1; j < H; j++) begin
               if ((j & (2*h - 1)) == h) l[j-1] = l[j+h-1];
            end
         end
      end
      w_l_fwd = l;
      w_y     = '0;
      w_c_fwd = '0;
      w_c_bwd = '0;
      for (int j = 0; j < H; j++) begin
         w_y[2*j]     = w_t_fwd[j] ? r_c[2*j+1] : r_c[2*j];
         w_y[2*j+1]   = w_t_fwd[j] ? r_c[2*j]   : r_c[2*j+1];
         w_c_fwd[j]   = w_y[2*j];
         w_c_fwd[j+H] = w_y[2*j+1];
         w_c_bwd[2*j]   = r_c[j];
         w_c_bwd[2*j+1] = r_c[j+H];
      end
      w_t_bwd  = r_nr ? (~r_lifo[0] & ~r_c[H-1:0]) : '0;
      w_b_pack = '0;
      for (int s2 = 0; s2 < NS; s2++) begin
         w_b_pack[(NS-1-s2)*H +: H] = r_inv ? r_slot[NS-1-s2] : r_slot[s2];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_k         <= '0;
         r_c         <= '0;
         r_di        <= '0;
         r_nr        <= 1'b0;
         r_inv       <= 1'b0;
         for (int i = 0; i < LOG2N; i++) r_lifo[i] <= '0;
         for (int i = 0; i < NS; i++)    r_slot[i] <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_b     <= '0;
         r_out_di    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_c        <= bus.in_ci;
                  r_di       <= bus.in_di;
                  r_nr       <= bus.in_nr;
                  r_inv      <= bus.in_inv;
                  r_k        <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= FWD;
               end
            end
            FWD: begin
               r_lifo[0] <= w_l_fwd;
               for (int i = 1; i < LOG2N; i++) r_lifo[i] <= r_lifo[i-1];
               // Slots shift toward index 0 so slot 0 ends up holding the first stage.
               for (int i = 0; i < NS - 1; i++) r_slot[i] <= r_slot[i+1];
               r_slot[NS-1] <= w_t_fwd;
               r_c <= w_c_fwd;
               if (r_k == K_LAST) begin
                  r_k     <= '0;
                  r_state <= BWD;
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            BWD: begin
               if (r_k == K_FIN) begin
                  r_out_b     <= w_b_pack;
                  r_out_di    <= r_di;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  for (int i = 0; i < LOG2N - 1; i++) r_lifo[i] <= r_lifo[i+1];
                  r_lifo[LOG2N-1] <= '0;
                  for (int i = 0; i < NS - 1; i++) r_slot[i] <= r_slot[i+1];
                  r_slot[NS-1] <= w_t_bwd;
                  r_c <= w_c_bwd;
                  r_k <= r_k + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_b     = r_out_b;
   assign bus.out_di    = r_out_di;
endmodule
